// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the instruction/data memory-port arbiter.
package mem_arb_pkg;

  // Access sequencer: grant in IDLE, RAM samples in MEM, owner acked in RESP.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // Which port owns the access currently in flight.
  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

  // Width needed to count data grants from 0 up to max_streak inclusive.
  function automatic int streak_width(input int max_streak);
    return $clog2(max_streak + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_prio_sel.sv
// Grant policy: data wins ties unless the fetch port has waited through a
// full streak of data grants. Only meaningful when at least one request is up.
import mem_arb_pkg::*;

module arb_prio_sel (
  input  logic       i_req,
  input  logic       d_req,
  input  logic       streak_max,
  output arb_owner_t owner
);

  // Fixed data priority with a starvation override for fetch
  always_comb begin
    // NOTE: assign a default first so every path drives owner and no latch is inferred.
    owner = OWN_D;
    if (i_req && (!d_req || streak_max)) begin
      owner = OWN_I;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM (1-cycle read latency) between the
// instruction-fetch port and the data port. One access per three cycles:
// IDLE (arbitrate, register m_*), MEM (RAM samples), RESP (owner acked, read
// data passed straight through from the RAM).
import mem_arb_pkg::*;

module mem_port_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 10,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam int                  STREAK_W   = streak_width(MAX_D_STREAK);
  localparam logic [STREAK_W-1:0] STREAK_TOP = STREAK_W'(MAX_D_STREAK);

  arb_state_t          state;
  arb_state_t          state_next;
  arb_owner_t          owner;      // port of the access in flight
  arb_owner_t          grant;      // policy decision for this IDLE cycle
  logic                acc_we;     // access in flight is a data write
  logic [STREAK_W-1:0] streak;     // data grants taken while fetch waited
  logic                any_req;
  logic                streak_max;

  assign any_req    = i_req | d_req;
  assign streak_max = (streak == STREAK_TOP);

  arb_prio_sel u_prio_sel (
    .i_req      (i_req),
    .d_req      (d_req),
    .streak_max (streak_max),
    .owner      (grant)
  );

  // State register; reset abandons any access in flight
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  // Next state, acks and read-data pass-through
  always_comb begin
    state_next = state;
    i_ack      = 1'b0;
    d_ack      = 1'b0;
    i_rdata    = '0;
    d_rdata    = '0;
    case (state)
      IDLE: if (any_req) state_next = MEM;
      MEM:  state_next = RESP;
      RESP: begin
        state_next = IDLE;
        if (owner == OWN_I) begin
          i_ack   = 1'b1;
          i_rdata = m_rdata;
        end else begin
          d_ack = 1'b1;
          if (!acc_we) d_rdata = m_rdata;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Memory command registers and owner latch, loaded when a grant is made
  always_ff @(posedge CLK) begin
    if (RESET) begin
      m_en    <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      owner   <= OWN_I;
      acc_we  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            m_en  <= 1'b1;
            owner <= grant;
            if (grant == OWN_D) begin
              m_we    <= d_we;
              m_addr  <= d_addr;
              m_wdata <= d_wdata;
              acc_we  <= d_we;
            end else begin
              m_we    <= 1'b0;
              m_addr  <= i_addr;
              acc_we  <= 1'b0;
            end
          end else begin
            m_en <= 1'b0;
            m_we <= 1'b0;
          end
        end
        MEM: begin
          // RAM has sampled the command at the end of this cycle
          m_en <= 1'b0;
          m_we <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Starvation counter: data grants taken while fetch was also waiting
  always_ff @(posedge CLK) begin
    if (RESET) begin
      streak <= '0;
    end else if (state == IDLE) begin
      if (!i_req || grant == OWN_I) streak <= '0;
      else if (!streak_max)         streak <= streak + STREAK_W'(1);
    end
  end

  // Protocol monitor: a pending request must hold its inputs until acked,
  // and both ports are never acked together. Not part of the datapath.
  logic              i_req_q, i_ack_q, d_req_q, d_ack_q, d_we_q;
  logic [ADDR_W-1:0] i_addr_q, d_addr_q;
  logic [DATA_W-1:0] d_wdata_q;

  // Previous-cycle request snapshot and stability checks
  always_ff @(posedge CLK) begin
    if (RESET) begin
      i_req_q   <= 1'b0;
      i_ack_q   <= 1'b0;
      d_req_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      d_we_q    <= 1'b0;
      i_addr_q  <= '0;
      d_addr_q  <= '0;
      d_wdata_q <= '0;
    end else begin
      if (i_req_q && !i_ack_q) begin
        assert (i_req && i_addr == i_addr_q);
      end
      if (d_req_q && !d_ack_q) begin
        assert (d_req && d_we == d_we_q && d_addr == d_addr_q && d_wdata == d_wdata_q);
      end
      assert (!(i_ack && d_ack));
      i_req_q   <= i_req;
      i_ack_q   <= i_ack;
      d_req_q   <= d_req;
      d_ack_q   <= d_ack;
      d_we_q    <= d_we;
      i_addr_q  <= i_addr;
      d_addr_q  <= d_addr;
      d_wdata_q <= d_wdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a behavioural
// 1-cycle-latency RAM and a reference memory for the back-to-back sequence.
module tb_mem_port_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              i_req, d_req, d_we;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              i_ack, d_ack, m_en, m_we;
  logic [DATA_W-1:0] i_rdata, d_rdata, m_wdata;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_rdata = '0;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] ram     [0:1023];
  logic [DATA_W-1:0] ref_mem [0:1023];

  mem_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_D_STREAK(4)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_ack   (i_ack),
    .i_rdata (i_rdata),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_ack   (d_ack),
    .d_rdata (d_rdata),
    .m_en    (m_en),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata)
  );

  always #5 CLK = ~CLK;

  // Synchronous single-port RAM; the fetch word is preloaded while in reset
  always @(posedge CLK) begin
    if (RESET) ram[4] <= 32'h0050_0093;
    if (m_en) begin
      if (m_we) ram[m_addr] <= m_wdata;
      else      m_rdata     <= ram[m_addr];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks the full idle picture: no command, no acks, zero read buses
  task automatic check_quiet(input string tag);
    check({tag, "_m_en"},    m_en,    0);
    check({tag, "_i_ack"},   i_ack,   0);
    check({tag, "_d_ack"},   d_ack,   0);
    check({tag, "_i_rdata"}, i_rdata, 0);
    check({tag, "_d_rdata"}, d_rdata, 0);
  endtask

  // Back-to-back data stream: write/read mix checked against ref_mem
  localparam int NOPS = 6;
  logic              op_we    [NOPS] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [ADDR_W-1:0] op_addr  [NOPS] = '{10'h020, 10'h021, 10'h020, 10'h021, 10'h020, 10'h020};
  logic [DATA_W-1:0] op_wdata [NOPS] = '{32'h1111_2222, 32'hA5A5_5A5A, 32'h0, 32'h0, 32'hCAFE_F00D, 32'h0};

  initial begin
    logic exp_d;
    logic [DATA_W-1:0] exp_rd;

    // 1: reset held two cycles with both requests up
    RESET = 1'b1; i_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
    i_addr = 10'h004; d_addr = 10'h010; d_wdata = 32'h1234_5678;
    step(); step();
    check_quiet("rst");
    check("rst_m_we",    m_we,    0);
    check("rst_m_addr",  m_addr,  0);
    check("rst_m_wdata", m_wdata, 0);
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    RESET = 1'b0;
    step();
    check("post_rst_idle_m_en", m_en, 0);

    // 2: fetch only from address 4
    i_req = 1'b1; i_addr = 10'h004;
    step();
    check("f_n1_m_en",   m_en,   1);
    check("f_n1_m_we",   m_we,   0);
    check("f_n1_m_addr", m_addr, 10'h004);
    check("f_n1_i_ack",  i_ack,  0);
    check("f_n1_d_ack",  d_ack,  0);
    step();
    check("f_n2_i_ack",   i_ack,   1);
    check("f_n2_i_rdata", i_rdata, 32'h0050_0093);
    check("f_n2_d_ack",   d_ack,   0);
    check("f_n2_m_en",    m_en,    0);
    step();
    i_req = 1'b0;
    check("f_n3_i_ack", i_ack, 0);

    // 3: write 0x010 then re-arm immediately with a read of it
    d_req = 1'b1; d_we = 1'b1; d_addr = 10'h010; d_wdata = 32'hDEAD_BEEF;
    step();
    check("w_n1_m_en",    m_en,    1);
    check("w_n1_m_we",    m_we,    1);
    check("w_n1_m_addr",  m_addr,  10'h010);
    check("w_n1_m_wdata", m_wdata, 32'hDEAD_BEEF);
    step();
    check("w_n2_d_ack",   d_ack,   1);
    check("w_n2_d_rdata", d_rdata, 0);
    check("w_n2_i_ack",   i_ack,   0);
    step();
    d_we = 1'b0; d_wdata = '0;
    check("r_gap_m_en", m_en, 0);
    step();
    check("r_n1_m_en",   m_en,   1);
    check("r_n1_m_we",   m_we,   0);
    check("r_n1_m_addr", m_addr, 10'h010);
    step();
    check("r_n2_d_ack",   d_ack,   1);
    check("r_n2_d_rdata", d_rdata, 32'hDEAD_BEEF);
    step();
    d_req = 1'b0;

    // 4: sustained contention, expected grants D,D,D,D,I,D,D,D,D,I
    i_req = 1'b1; i_addr = 10'h004;
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h010;
    for (int k = 0; k < 10; k++) begin
      exp_d = (k % 5) != 4;
      step();
      check($sformatf("c%0d_mem_acks", k), {i_ack, d_ack}, 2'b00);
      step();
      check($sformatf("c%0d_d_ack", k), d_ack, exp_d);
      check($sformatf("c%0d_i_ack", k), i_ack, !exp_d);
      check($sformatf("c%0d_rdata", k), exp_d ? d_rdata : i_rdata,
            exp_d ? 32'hDEAD_BEEF : 32'h0050_0093);
      step();
      check($sformatf("c%0d_idle_acks", k), {i_ack, d_ack}, 2'b00);
    end
    i_req = 1'b0;
    step(); step();
    check("c_tail_d_ack", d_ack, 1);
    step();
    d_req = 1'b0;

    // 5: reset during MEM of a contended data read
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 10'h010;
    step();
    check("rm_mem_m_en",  m_en,       1);
    check("rm_mem_owner", m_addr,     10'h010);
    check("rm_streak_1",  dut.streak, 1);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    check_quiet("rm_abandon");
    check("rm_streak_0", dut.streak, 0);
    step();
    check("rm_retry_m_en",   m_en,   1);
    check("rm_retry_m_addr", m_addr, 10'h010);
    step();
    check("rm_retry_d_ack",   d_ack,   1);
    check("rm_retry_d_rdata", d_rdata, 32'hDEAD_BEEF);
    check("rm_retry_i_ack",   i_ack,   0);
    step();
    d_req = 1'b0;
    step(); step();
    check("rm_fetch_i_ack",   i_ack,   1);
    check("rm_fetch_i_rdata", i_rdata, 32'h0050_0093);
    step();
    i_req = 1'b0;

    // 6: back-to-back data accesses, re-armed the cycle after each ack
    for (int k = 0; k < NOPS; k++) begin
      d_req = 1'b1; d_we = op_we[k]; d_addr = op_addr[k]; d_wdata = op_wdata[k];
      step();
      check($sformatf("b%0d_m_en", k),   m_en,   1);
      check($sformatf("b%0d_m_addr", k), m_addr, op_addr[k]);
      step();
      exp_rd = op_we[k] ? '0 : ref_mem[op_addr[k]];
      if (op_we[k]) ref_mem[op_addr[k]] = op_wdata[k];
      check($sformatf("b%0d_d_ack", k),   d_ack,   1);
      check($sformatf("b%0d_d_rdata", k), d_rdata, exp_rd);
      step();
    end
    d_req = 1'b0;
    step();
    check("b_end_quiet_m_en", m_en, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
